// File: rtl/sound_event_scheduler.sv
// sound_event_scheduler: captures game events as pending requests, grants them
// by fixed priority (bad > good > dir) and sequences tone / gap timing for the
// downstream sound_generator. Tracks a user mute toggled by the button.
// Define SOUND_MELODY_EN to play a second note (TONE_BAD2) after a bad grant.
module sound_event_scheduler #(
  parameter int         TICK_DIV  = 10000,
  parameter int         DUR_GOOD  = 100,
  parameter int         DUR_BAD   = 200,
  parameter int         DUR_DIR   = 30,
  parameter int         GAP_TICKS = 5,
  parameter logic [7:0] TONE_GOOD = 8'd40,
  parameter logic [7:0] TONE_BAD  = 8'd200,
  parameter logic [7:0] TONE_BAD2 = 8'd240,
  parameter logic [7:0] TONE_DIR  = 8'd20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       goodColl_i,
  input  logic       badColl_i,
  input  logic       button_i,
  input  logic [3:0] direction_i,
  output logic [7:0] tone_o,
  output logic       play_o,
  output logic       mute_o,
  output logic [2:0] pending_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = 16;

`ifdef SOUND_MELODY_EN
  typedef enum logic [1:0] {IDLE, PLAY, GAP, PLAY2} state_t;
`else
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
`endif

  typedef enum logic [1:0] {SRC_DIR, SRC_GOOD, SRC_BAD} src_t;

  logic          good_q, bad_q, btn_q;
  logic [3:0]    dir_q;
  logic          good_ev, bad_ev, btn_ev, dir_ev;
  logic [2:0]    ev, grant, pend_n;
  state_t        state, state_n;
  src_t          src, src_n;
  logic [PW-1:0] presc, presc_n;
  logic [DW-1:0] dur_cnt, dur_n;
  logic          tick, last_tick;
  logic [7:0]    tone_n;
  logic          play_n;

  // A programmed duration of 0 behaves as 1 tick.
  function automatic logic [DW-1:0] dur_ticks(input int d);
    return (d < 1) ? DW'(1) : DW'(d);
  endfunction

  function automatic logic [2:0] pick(input logic [2:0] p);
    if (p[2])      return 3'b100;
    else if (p[1]) return 3'b010;
    else if (p[0]) return 3'b001;
    else           return 3'b000;
  endfunction

  function automatic src_t src_of(input logic [2:0] g);
    if (g[2])      return SRC_BAD;
    else if (g[1]) return SRC_GOOD;
    else           return SRC_DIR;
  endfunction

  function automatic logic [DW-1:0] src_dur(input src_t s);
    case (s)
      SRC_BAD:  return dur_ticks(DUR_BAD);
      SRC_GOOD: return dur_ticks(DUR_GOOD);
      default:  return dur_ticks(DUR_DIR);
    endcase
  endfunction

  assign good_ev   = goodColl_i & ~good_q;
  assign bad_ev    = badColl_i & ~bad_q;
  assign btn_ev    = button_i & ~btn_q;
  assign dir_ev    = (direction_i != dir_q) && (direction_i != '0);
  assign ev        = {bad_ev, good_ev, dir_ev};
  assign tick      = (presc == PW'(TICK_DIV - 1));
  assign last_tick = tick && (dur_cnt <= DW'(1));

  // Previous-value registers for the input edge detectors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_q <= 1'b0;
      bad_q  <= 1'b0;
      btn_q  <= 1'b0;
      dir_q  <= '0;
    end else begin
      good_q <= goodColl_i;
      bad_q  <= badColl_i;
      btn_q  <= button_i;
      dir_q  <= direction_i;
    end
  end

  // Set beats grant on the same bit; muting clears and blocks all requests.
  assign pend_n = mute_o ? '0 : ((pending_o & ~grant) | ev);

  // Mute toggle and pending request flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mute_o    <= 1'b0;
      pending_o <= '0;
    end else begin
      if (btn_ev) mute_o <= ~mute_o;
      pending_o <= pend_n;
    end
  end

  // State, granted source, duration counter and prescaler registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      src     <= SRC_DIR;
      dur_cnt <= '0;
      presc   <= '0;
    end else begin
      state   <= state_n;
      src     <= src_n;
      dur_cnt <= dur_n;
      presc   <= presc_n;
    end
  end

  // Next-state, grant selection and duration bookkeeping.
  // A grant available when the gap expires goes straight to PLAY, so the
  // silence between sounds is exactly GAP_TICKS ticks.
  always_comb begin
    state_n = state;
    src_n   = src;
    dur_n   = dur_cnt;
    grant   = '0;
    if (mute_o) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          grant = pick(pending_o);
        end
        PLAY: begin
          if (pending_o[2] && (src != SRC_BAD)) begin
            grant = 3'b100;
          end else if (last_tick) begin
            state_n = GAP;
            dur_n   = dur_ticks(GAP_TICKS);
`ifdef SOUND_MELODY_EN
            if (src == SRC_BAD) begin
              state_n = PLAY2;
              dur_n   = dur_ticks(DUR_BAD);
            end
`endif
          end else if (tick) begin
            dur_n = dur_cnt - DW'(1);
          end
        end
`ifdef SOUND_MELODY_EN
        PLAY2: begin
          if (last_tick) begin
            state_n = GAP;
            dur_n   = dur_ticks(GAP_TICKS);
          end else if (tick) begin
            dur_n = dur_cnt - DW'(1);
          end
        end
`endif
        GAP: begin
          if (last_tick) begin
            grant   = pick(pending_o);
            state_n = IDLE;
          end else if (tick) begin
            dur_n = dur_cnt - DW'(1);
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
      if (grant != '0) begin
        state_n = PLAY;
        src_n   = src_of(grant);
        dur_n   = src_dur(src_of(grant));
      end
    end
  end

  // Prescaler restarts on every transition, including a preempting restart.
  assign presc_n = (tick || (state_n != state) || (grant != '0)) ? '0 : presc + PW'(1);

  // Next output values derived from the upcoming state.
  always_comb begin
    tone_n = '0;
    play_n = 1'b0;
    case (state_n)
      PLAY: begin
        play_n = 1'b1;
        case (src_n)
          SRC_BAD:  tone_n = TONE_BAD;
          SRC_GOOD: tone_n = TONE_GOOD;
          default:  tone_n = TONE_DIR;
        endcase
      end
`ifdef SOUND_MELODY_EN
      PLAY2: begin
        play_n = 1'b1;
        tone_n = TONE_BAD2;
      end
`endif
      default: begin
        tone_n = '0;
        play_n = 1'b0;
      end
    endcase
  end

  // Registered tone and play outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_o <= '0;
      play_o <= 1'b0;
    end else begin
      tone_o <= tone_n;
      play_o <= play_n;
    end
  end

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Self-checking bench for sound_event_scheduler: table-driven scenarios,
// hand-written mute/reset sequences and randomized traffic against a
// cycle-count reference model.
module tb_sound_event_scheduler;

  localparam int TD = 4;
  localparam int DG = 3;
  localparam int DB = 5;
  localparam int DD = 2;
  localparam int GT = 1;
`ifdef SOUND_MELODY_EN
  localparam bit MELODY = 1'b1;
`else
  localparam bit MELODY = 1'b0;
`endif

  localparam int PH_IDLE  = 0;
  localparam int PH_PLAY  = 1;
  localparam int PH_GAP   = 2;
  localparam int PH_PLAY2 = 3;

  logic       tb_clk = 1'b0;
  logic       rst;
  logic       goodColl_i, badColl_i, button_i;
  logic [3:0] direction_i;
  logic [7:0] tone_o;
  logic       play_o, mute_o;
  logic [2:0] pending_o;

  int n_checks = 0;
  int n_fail   = 0;

  sound_event_scheduler #(
    .TICK_DIV (TD),
    .DUR_GOOD (DG),
    .DUR_BAD  (DB),
    .DUR_DIR  (DD),
    .GAP_TICKS(GT)
  ) dut (
    .clk        (tb_clk),
    .rst        (rst),
    .goodColl_i (goodColl_i),
    .badColl_i  (badColl_i),
    .button_i   (button_i),
    .direction_i(direction_i),
    .tone_o     (tone_o),
    .play_o     (play_o),
    .mute_o     (mute_o),
    .pending_o  (pending_o)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: phases measured in whole clock cycles.
  int         m_phase, m_src, m_left;
  logic [2:0] m_pend;
  bit         m_mute, m_pg, m_pb, m_pbtn;
  logic [3:0] m_pd;

  task automatic model_reset();
    m_phase = PH_IDLE; m_src = 0; m_left = 0; m_pend = '0;
    m_mute = 0; m_pg = 0; m_pb = 0; m_pbtn = 0; m_pd = '0;
  endtask

  function automatic int cycles_of(input int s);
    return (s == 2) ? DB * TD : (s == 1) ? DG * TD : DD * TD;
  endfunction

  function automatic logic [2:0] top_req(input logic [2:0] p);
    if (p[2]) return 3'b100;
    if (p[1]) return 3'b010;
    if (p[0]) return 3'b001;
    return 3'b000;
  endfunction

  task automatic model_step();
    logic [2:0] evs, g;
    bit eb;
    evs[2] = badColl_i && !m_pb;
    evs[1] = goodColl_i && !m_pg;
    evs[0] = (direction_i != m_pd) && (direction_i != 4'h0);
    eb     = button_i && !m_pbtn;
    g      = 3'b000;
    if (m_mute) begin
      m_phase = PH_IDLE;
    end else begin
      case (m_phase)
        PH_IDLE: g = top_req(m_pend);
        PH_PLAY: begin
          if (m_pend[2] && m_src != 2) g = 3'b100;
          else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
              if (MELODY && m_src == 2) begin m_phase = PH_PLAY2; m_left = DB * TD; end
              else begin m_phase = PH_GAP; m_left = GT * TD; end
            end
          end
        end
        PH_PLAY2: begin
          m_left = m_left - 1;
          if (m_left == 0) begin m_phase = PH_GAP; m_left = GT * TD; end
        end
        default: begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            g = top_req(m_pend);
            if (g == 3'b000) m_phase = PH_IDLE;
          end
        end
      endcase
      if (g != 3'b000) begin
        m_src   = g[2] ? 2 : g[1] ? 1 : 0;
        m_phase = PH_PLAY;
        m_left  = cycles_of(m_src);
      end
    end
    m_pend = m_mute ? 3'b000 : ((m_pend & ~g) | evs);
    if (eb) m_mute = !m_mute;
    m_pg = goodColl_i; m_pb = badColl_i; m_pbtn = button_i; m_pd = direction_i;
  endtask

  function automatic int exp_tone();
    if (m_phase == PH_PLAY)  return (m_src == 2) ? 200 : (m_src == 1) ? 40 : 20;
    if (m_phase == PH_PLAY2) return 240;
    return 0;
  endfunction

  function automatic int exp_play();
    return (m_phase == PH_PLAY || m_phase == PH_PLAY2) ? 1 : 0;
  endfunction

  // One clock: advance model at the edge, compare DUT just after it.
  task automatic step();
    @(posedge tb_clk);
    model_step();
    #1;
    check("model_tone", int'(tone_o), exp_tone());
    check("model_play", int'(play_o), exp_play());
    check("model_mute", int'(mute_o), int'(m_mute));
    check("model_pend", int'(pending_o), int'(m_pend));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tone"}, int'(tone_o), 0);
    check({tag, "_play"}, int'(play_o), 0);
    check({tag, "_mute"}, int'(mute_o), 0);
    check({tag, "_pend"}, int'(pending_o), 0);
  endtask

  typedef struct {
    logic       g, b, btn;
    logic [3:0] dir;
    int         cyc;
    logic [7:0] tone;
    logic       play, mute;
    logic [2:0] pend;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic g, input logic b, input logic btn, input logic [3:0] dir,
                     input int cyc, input logic [7:0] tone, input logic play,
                     input logic mute, input logic [2:0] pend);
    vec_t v;
    v.g = g; v.b = b; v.btn = btn; v.dir = dir; v.cyc = cyc;
    v.tone = tone; v.play = play; v.mute = mute; v.pend = pend;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    goodColl_i = 0; badColl_i = 0; button_i = 0; direction_i = 4'h0;
    model_reset();
    #12;
    check_zero("reset");
    @(negedge tb_clk);
    rst = 1'b0;

    // Single good pulse: 12 cycles of 40, then 4 silent.
    add(1, 0, 0, 4'h0, 1,       8'd0,   0, 0, 3'b010);
    add(0, 0, 0, 4'h0, DG * TD, 8'd40,  1, 0, 3'b000);
    add(0, 0, 0, 4'h0, GT * TD, 8'd0,   0, 0, 3'b000);
    add(0, 0, 0, 4'h0, 2,       8'd0,   0, 0, 3'b000);
    // Good and dir together: good first, gap, then dir.
    add(1, 0, 0, 4'h1, 1,       8'd0,   0, 0, 3'b011);
    add(0, 0, 0, 4'h1, DG * TD, 8'd40,  1, 0, 3'b001);
    add(0, 0, 0, 4'h1, GT * TD, 8'd0,   0, 0, 3'b001);
    add(0, 0, 0, 4'h1, DD * TD, 8'd20,  1, 0, 3'b000);
    add(0, 0, 0, 4'h1, GT * TD, 8'd0,   0, 0, 3'b000);
    // Bad pulse, optionally two-note.
    add(0, 1, 0, 4'h1, 1,       8'd0,   0, 0, 3'b100);
    add(0, 0, 0, 4'h1, DB * TD, 8'd200, 1, 0, 3'b000);
    if (MELODY) add(0, 0, 0, 4'h1, DB * TD, 8'd240, 1, 0, 3'b000);
    add(0, 0, 0, 4'h1, GT * TD, 8'd0,   0, 0, 3'b000);
    // Bad rises in the 5th cycle of a good sound: preempts with no gap.
    add(1, 0, 0, 4'h1, 1,       8'd0,   0, 0, 3'b010);
    add(0, 0, 0, 4'h1, 4,       8'd40,  1, 0, 3'b000);
    add(0, 1, 0, 4'h1, 1,       8'd40,  1, 0, 3'b100);
    add(0, 0, 0, 4'h1, DB * TD, 8'd200, 1, 0, 3'b000);
    if (MELODY) add(0, 0, 0, 4'h1, DB * TD, 8'd240, 1, 0, 3'b000);
    add(0, 0, 0, 4'h1, GT * TD, 8'd0,   0, 0, 3'b000);

    foreach (vecs[i]) begin
      goodColl_i = vecs[i].g; badColl_i = vecs[i].b;
      button_i = vecs[i].btn; direction_i = vecs[i].dir;
      for (int k = 0; k < vecs[i].cyc; k++) begin
        step();
        check("vec_tone", int'(tone_o), int'(vecs[i].tone));
        check("vec_play", int'(play_o), int'(vecs[i].play));
        check("vec_mute", int'(mute_o), int'(vecs[i].mute));
        check("vec_pend", int'(pending_o), int'(vecs[i].pend));
      end
    end

    // Mute during PLAY with dir pending.
    goodColl_i = 1; step();
    goodColl_i = 0; direction_i = 4'h2; step();
    check("mute_pre_tone", int'(tone_o), 40);
    check("mute_pre_pend", int'(pending_o), 1);
    step(); step();
    button_i = 1; step();
    check("mute_set", int'(mute_o), 1);
    step();
    check("mute_tone", int'(tone_o), 0);
    check("mute_play", int'(play_o), 0);
    check("mute_pend", int'(pending_o), 0);
    button_i = 0; goodColl_i = 1; step();
    goodColl_i = 0; repeat (4) step();
    check("muted_good_tone", int'(tone_o), 0);
    check("muted_good_pend", int'(pending_o), 0);
    button_i = 1; step();
    check("unmute", int'(mute_o), 0);
    button_i = 0; step(); step();
    check("unmute_idle_tone", int'(tone_o), 0);
    goodColl_i = 1; step();
    check("unmute_good_pend", int'(pending_o), 2);
    goodColl_i = 0; step();
    check("unmute_good_tone", int'(tone_o), 40);
    repeat (DG * TD + GT * TD + 2) step();

    // Asynchronous reset mid-sound, off the clock edge.
    goodColl_i = 1; step();
    goodColl_i = 0; repeat (3) step();
    check("pre_rst_play", int'(play_o), 1);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    repeat (2) @(posedge tb_clk);
    #1;
    check_zero("held_rst");
    @(negedge tb_clk);
    goodColl_i = 0; badColl_i = 0; button_i = 0; direction_i = 4'h0;
    rst = 1'b0;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) goodColl_i = ~goodColl_i;
      if ($urandom_range(0, 39) == 0) badColl_i = ~badColl_i;
      if ($urandom_range(0, 149) == 0) button_i = ~button_i;
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 4))
          0: direction_i = 4'h0;
          1: direction_i = 4'h1;
          2: direction_i = 4'h2;
          3: direction_i = 4'h4;
          default: direction_i = 4'h8;
        endcase
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sound_event_scheduler.md
# sound_event_scheduler

Arbiter and sequencer in front of the `sound_generator` tone datapath. It captures game events (good collision, bad collision, direction change) as pending requests and grants them by fixed priority. It plays each granted request as a tone code for a programmed duration, with a silent gap between sounds, and tracks a user mute toggled by the button.

## Interface
- `TICK_DIV`, 10000: clk cycles per duration tick.
- `DUR_GOOD`, 100: ticks the good-collision tone plays.
- `DUR_BAD`, 200: ticks the bad-collision tone (each note) plays.
- `DUR_DIR`, 30: ticks the direction tone plays.
- `GAP_TICKS`, 5: silent ticks after each sound.
- `TONE_GOOD` / `TONE_BAD` / `TONE_BAD2` / `TONE_DIR`, 8'd40 / 8'd200 / 8'd240 / 8'd20: tone codes driven to `sound_generator`.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `goodColl_i` in 1: level; rising edge = event.
- `badColl_i` in 1: level; rising edge = event.
- `button_i` in 1: level; rising edge toggles mute.
- `direction_i` in 4: one-hot heading; any change to a nonzero value = direction event.
- `tone_o` out 8: tone code; 0 = silent.
- `play_o` out 1: high while a sound is in PLAY.
- `mute_o` out 1: mute state.
- `pending_o` out 3: {bad, good, dir} pending flags.

## Operation
- Edge detectors register the previous value of each input. A direction event requires `direction_i != prev` and `direction_i != 0`.
- Each event sets its pending bit. A grant clears that bit. If an event and a grant of the same type occur in the same cycle, set wins and the bit stays 1.
- Priority is bad > good > dir.
- FSM states: IDLE, PLAY, GAP (plus PLAY2 when the melody is enabled).
  - IDLE: if any pending bit is set and not muted, grant the highest-priority request, clear its bit, load its duration and tone, then go to PLAY. Otherwise `tone_o`=0.
  - PLAY: `tone_o`=granted tone, `play_o`=1. At the end of the duration go to GAP.
  - GAP: `tone_o`=0, `play_o`=0 for `GAP_TICKS` ticks, then go to IDLE.
- Preemption: while PLAY is serving good or dir, a set bad pending bit aborts the sound immediately. The same cycle grants bad and restarts PLAY with no gap. A lower-priority or equal-priority event during PLAY only stays pending.
- Mute: a button edge toggles `mute_o`. Entering mute forces IDLE, clears all pending bits, and blocks pending sets while muted. Leaving mute resumes normal operation with nothing pending.
- Prescaler: counts 0..`TICK_DIV`-1 and emits a tick on wrap. It is cleared on every state transition. PLAY therefore lasts exactly DUR×`TICK_DIV` cycles and GAP lasts `GAP_TICKS`×`TICK_DIV` cycles.
- Duration counter width is at least 8 bits. A duration of 0 is treated as 1.

## Timing
- Reset values: `tone_o`=0, `play_o`=0, `mute_o`=0, `pending_o`=0. State = IDLE, prescaler = 0, all edge registers = 0.
- All outputs are registered.
- Event latency:
  - The input rises before posedge N.
  - `pending_o` bit is high after posedge N.
  - `play_o`/`tone_o` are valid after posedge N+1, and the pending bit clears at the same edge.
- A sound ends after posedge N+1+DUR×`TICK_DIV`; `play_o` falls there.
- The next grant happens at the first edge after GAP expires.
- Preemption takes effect one edge after bad pending rises.
- Mute takes effect one edge after the button edge is detected: `play_o`=0 and `tone_o`=0.
- `rst` asserted mid-sound forces the reset values immediately, without waiting for a clock edge.

## Configuration
- `SOUND_MELODY_EN` defined:
  - A bad grant plays `TONE_BAD` for `DUR_BAD` ticks, then PLAY2 with `TONE_BAD2` for `DUR_BAD` ticks, with no gap between the notes.
  - `play_o` stays high across both notes.
  - PLAY2 cannot be preempted.
- Undefined: bad plays the single `TONE_BAD` note, and PLAY2 does not exist.

## Test plan
All scenarios use parameters `TICK_DIV`=4, `DUR_GOOD`=3, `DUR_BAD`=5, `DUR_DIR`=2, `GAP_TICKS`=1.
- Reset: assert `rst` mid-PLAY, off a clock edge → all outputs 0 immediately; they stay 0 while reset is held.
- Single good pulse → `tone_o`=40 and `play_o`=1 for exactly 12 cycles starting 2 edges after the rise, then 4 silent cycles.
- good and dir raised the same cycle → `pending_o`=3'b011, good plays first (12 cycles), gap (4 cycles), then `tone_o`=20 for 8 cycles.
- Preemption: bad rises during cycle 5 of a good sound → `tone_o`=200 one edge later, held for 20 cycles, with no gap before it.
- Mute: button edge during PLAY with dir pending → `mute_o`=1, `tone_o`=0, `pending_o`=0. A following good pulse is ignored. A second button edge gives `mute_o`=0.
- With `SOUND_MELODY_EN`: bad pulse → 20 cycles of 200, then 20 cycles of 240, with `play_o` continuously high. Without the macro: 20 cycles of 200, then the gap.
